// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Fetches over a variable-latency req/valid port, absorbs stalls in a one-word hold buffer, and squashes wrong-path fetches.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PC_IFWrite,
  input  logic        Z,
  input  logic        J,
  input  logic        JR,
  input  logic [31:0] BranchAddr,
  input  logic [31:0] JumpAddr,
  input  logic [31:0] JrAddr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] PC_if,
  output logic [31:0] Instruction_id,
  output logic [31:0] NextPC_id,
  output logic        Valid_id
);

  typedef enum logic {S_FETCH, S_DROP} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_drop_addr, w_drop_addr_nxt;
  logic [31:0] r_instr, w_instr_nxt;
  logic [31:0] r_nextpc, w_nextpc_nxt;
  logic        r_valid, w_valid_nxt;
  logic [31:0] r_hold_instr, w_hold_instr_nxt;
  logic [31:0] r_hold_pc, w_hold_pc_nxt;
  logic        r_hold_full, w_hold_full_nxt;

  logic        w_redir;
  logic        w_req;
  logic        w_done;
  logic [31:0] w_target;
  logic [31:0] w_pc_plus4;

  assign w_redir    = r_valid & PC_IFWrite & (Z | J | JR);
  assign w_target   = (JR ? JrAddr : (J ? JumpAddr : BranchAddr)) & ~32'd3;
  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_req      = (r_state == S_DROP) | ~r_hold_full;
  assign w_done     = w_req & imem_valid;

  // While in DROP the address must stay on the request that is still outstanding.
  assign imem_req       = rst_n & w_req;
  assign imem_addr      = (r_state == S_DROP) ? r_drop_addr : r_pc;
  assign PC_if          = r_pc;
  assign Instruction_id = r_instr;
  assign NextPC_id      = r_nextpc;
  assign Valid_id       = r_valid;

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_drop_addr_nxt  = r_drop_addr;
    w_instr_nxt      = r_instr;
    w_nextpc_nxt     = r_nextpc;
    w_valid_nxt      = r_valid;
    w_hold_instr_nxt = r_hold_instr;
    w_hold_pc_nxt    = r_hold_pc;
    w_hold_full_nxt  = r_hold_full;

    case (r_state)
      S_FETCH: begin
        if (w_redir) begin
          w_instr_nxt     = NOP;
          w_nextpc_nxt    = 32'd0;
          w_valid_nxt     = 1'b0;
          w_pc_nxt        = w_target;
          w_hold_full_nxt = 1'b0;
          if (w_req & ~imem_valid) begin
            w_state_nxt     = S_DROP;
            w_drop_addr_nxt = r_pc;
          end
        end else if (w_done) begin
          if (PC_IFWrite) begin
            w_instr_nxt  = imem_rdata;
            w_nextpc_nxt = w_pc_plus4;
            w_valid_nxt  = 1'b1;
          end else begin
            w_hold_instr_nxt = imem_rdata;
            w_hold_pc_nxt    = w_pc_plus4;
            w_hold_full_nxt  = 1'b1;
          end
          w_pc_nxt = w_pc_plus4;
        end else if (PC_IFWrite) begin
          if (r_hold_full) begin
            w_instr_nxt     = r_hold_instr;
            w_nextpc_nxt    = r_hold_pc;
            w_valid_nxt     = 1'b1;
            w_hold_full_nxt = 1'b0;
          end else begin
            w_instr_nxt  = NOP;
            w_nextpc_nxt = 32'd0;
            w_valid_nxt  = 1'b0;
          end
        end
      end

      S_DROP: begin
        if (w_redir) begin
          w_pc_nxt        = w_target;
          w_hold_full_nxt = 1'b0;
        end
        if (PC_IFWrite) begin
          w_instr_nxt  = NOP;
          w_nextpc_nxt = 32'd0;
          w_valid_nxt  = 1'b0;
        end
        if (imem_valid) begin
          w_state_nxt = S_FETCH;
        end
      end

      default: w_state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_FETCH;
      r_pc         <= RESET_PC;
      r_drop_addr  <= 32'd0;
      r_instr      <= NOP;
      r_nextpc     <= 32'd0;
      r_valid      <= 1'b0;
      r_hold_instr <= NOP;
      r_hold_pc    <= 32'd0;
      r_hold_full  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_drop_addr  <= w_drop_addr_nxt;
      r_instr      <= w_instr_nxt;
      r_nextpc     <= w_nextpc_nxt;
      r_valid      <= w_valid_nxt;
      r_hold_instr <= w_hold_instr_nxt;
      r_hold_pc    <= w_hold_pc_nxt;
      r_hold_full  <= w_hold_full_nxt;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: program-order reference model feeds a scoreboard queue
// that a negedge monitor drains whenever IF/ID presents a valid instruction.
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        PC_IFWrite, Z, J, JR;
  logic [31:0] BranchAddr, JumpAddr, JrAddr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] PC_if, Instruction_id, NextPC_id;
  logic        Valid_id;

  if_stage #(.RESET_PC(RESET_PC), .NOP(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .PC_IFWrite(PC_IFWrite),
    .Z(Z), .J(J), .JR(JR),
    .BranchAddr(BranchAddr), .JumpAddr(JumpAddr), .JrAddr(JrAddr),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .PC_if(PC_if), .Instruction_id(Instruction_id),
    .NextPC_id(NextPC_id), .Valid_id(Valid_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] nextPc;
  } exp_t;

  exp_t        expQ[$];
  int          checks = 0;
  int          errors = 0;
  int          delivered = 0;
  logic [31:0] nextPush;
  bit          idValid;
  bit          expectBubble;
  logic        lastPcw;
  logic        lastBubble;
  logic [31:0] lastInstr, lastNext;
  logic        lastValid;

  int          fixedLat = 0;
  bit          randomLat = 0;
  int          waitCnt;
  int          curLat;
  logic        pend;
  logic [31:0] pendAddr;

  function automatic logic [31:0] memWord(logic [31:0] a);
    return a >> 2;
  endfunction

  // Memory: answers the current request once it has waited curLat cycles.
  assign imem_rdata = memWord(imem_addr);
  assign imem_valid = imem_req && (waitCnt >= curLat);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waitCnt  <= 0;
      curLat   <= fixedLat;
      pend     <= 1'b0;
      pendAddr <= 32'd0;
    end else begin
      pend     <= imem_req && !imem_valid;
      pendAddr <= imem_addr;
      if (imem_req && imem_valid) begin
        waitCnt <= 0;
        curLat  <= randomLat ? int'($urandom_range(0, 3)) : fixedLat;
      end else if (imem_req) begin
        waitCnt <= waitCnt + 1;
      end
    end
  end

  always @(posedge clk) begin
    lastPcw    <= PC_IFWrite;
    lastBubble <= expectBubble;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: after an advancing edge a valid IF/ID must match the next program-order entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        idValid   = 1'b0;
        lastInstr = NOP;
        lastNext  = 32'd0;
        lastValid = 1'b0;
      end else begin
        if (lastPcw) begin
          if (lastBubble) checkOutput("bubble_after_redirect", Valid_id, 32'd0);
          if (Valid_id) begin
            if (expQ.size() == 0) begin
              checks++;
              errors++;
              $display("[TB] FAIL unexpected_delivery: got %h expected none", Instruction_id);
            end else begin
              e = expQ.pop_front();
              checkOutput("instr", Instruction_id, e.instr);
              checkOutput("nextpc", NextPC_id, e.nextPc);
              delivered++;
              lastInstr = e.instr;
              lastNext  = e.nextPc;
            end
            idValid   = 1'b1;
            lastValid = 1'b1;
          end else begin
            checkOutput("bubble_instr", Instruction_id, NOP);
            checkOutput("bubble_nextpc", NextPC_id, 32'd0);
            idValid   = 1'b0;
            lastValid = 1'b0;
            lastInstr = NOP;
            lastNext  = 32'd0;
          end
        end else begin
          checkOutput("stall_instr", Instruction_id, lastInstr);
          checkOutput("stall_nextpc", NextPC_id, lastNext);
          checkOutput("stall_valid", Valid_id, lastValid);
        end
        if (pend) begin
          checkOutput("req_held", imem_req, 32'd1);
          checkOutput("addr_stable", imem_addr, pendAddr);
        end
      end
    end
  end

  // Drives one cycle of inputs and advances the program-order model, then waits past the edge.
  task automatic applyStimulus(input bit pcw, input bit z, input bit j, input bit jr,
                               input logic [31:0] ba, input logic [31:0] ja, input logic [31:0] jra);
    logic [31:0] tgt;
    bit redir;
    PC_IFWrite = pcw;
    Z = z;
    J = j;
    JR = jr;
    BranchAddr = ba;
    JumpAddr = ja;
    JrAddr = jra;
    redir = idValid && pcw && (z || j || jr);
    expectBubble = redir;
    if (redir) begin
      tgt = jr ? jra : (j ? ja : ba);
      tgt = {tgt[31:2], 2'b00};
      expQ.delete();
      nextPush = tgt;
    end
    while (expQ.size() < 4) begin
      expQ.push_back('{memWord(nextPush), nextPush + 32'd4});
      nextPush = nextPush + 32'd4;
    end
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input bit pcw);
    applyStimulus(pcw, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic clearModel();
    expQ.delete();
    nextPush = RESET_PC;
    expectBubble = 1'b0;
  endtask

  task automatic findPendingWithValidId(output bit found);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      idle(1'b1);
      if (Valid_id && imem_req && !imem_valid) found = 1'b1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("[TB] FAIL pending_search: got timeout expected pending fetch");
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] oldAddr;
    bit found;
    bit pcw, z, j, jr;
    logic [31:0] ba, ja, jra;

    PC_IFWrite = 1'b1; Z = 1'b0; J = 1'b0; JR = 1'b0;
    BranchAddr = 32'd0; JumpAddr = 32'd0; JrAddr = 32'd0;
    expectBubble = 1'b0;
    clearModel();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    checkOutput("reset_pc", PC_if, RESET_PC);
    checkOutput("reset_instr", Instruction_id, NOP);
    checkOutput("reset_nextpc", NextPC_id, 32'd0);
    checkOutput("reset_valid", Valid_id, 32'd0);
    checkOutput("reset_req", imem_req, 32'd0);
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Zero-latency streaming: one instruction per cycle from RESET_PC.
    for (int i = 0; i < 4; i++) idle(1'b1);
    checkOutput("t1_instr", Instruction_id, 32'h3);
    checkOutput("t1_nextpc", NextPC_id, 32'h10);
    checkOutput("t1_valid", Valid_id, 32'd1);

    // Two stall cycles: one word goes into the hold buffer and fetching pauses.
    idle(1'b0);
    checkOutput("t2_no_req", imem_req, 32'd0);
    checkOutput("t2_pc", PC_if, 32'h14);
    idle(1'b0);
    checkOutput("t2_held_instr", Instruction_id, 32'h3);
    idle(1'b1);
    checkOutput("t2_resume_instr", Instruction_id, 32'h4);
    checkOutput("t2_resume_nextpc", NextPC_id, 32'h14);

    // Taken branch costs exactly one bubble.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 32'd0, 32'd0);
    checkOutput("t3_bubble", Valid_id, 32'd0);
    checkOutput("t3_pc", PC_if, 32'h40);
    idle(1'b1);
    checkOutput("t3_target_instr", Instruction_id, 32'h10);
    checkOutput("t3_target_nextpc", NextPC_id, 32'h44);

    // JR beats J, target low bits cleared; a branch under stall is ignored.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'd0, 32'h300, 32'h203);
    checkOutput("t5_jr_pc", PC_if, 32'h200);
    idle(1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 32'd0, 32'd0);
    checkOutput("t5_no_redirect_pc", PC_if, 32'h208);
    checkOutput("t5_no_redirect_instr", Instruction_id, 32'h80);
    idle(1'b1);

    // Slow memory: a jump while a fetch is outstanding must drain it before refetching.
    fixedLat = 3;
    findPendingWithValidId(found);
    if (found) begin
      oldAddr = imem_addr;
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 32'h100, 32'd0);
      checkOutput("t4_drop_req", imem_req, 32'd1);
      checkOutput("t4_drop_addr", imem_addr, oldAddr);
      checkOutput("t4_pc", PC_if, 32'h100);
      for (int i = 0; i < 10 && imem_addr == oldAddr; i++) idle(1'b1);
      checkOutput("t4_new_addr", imem_addr, 32'h100);
      for (int i = 0; i < 10; i++) idle(1'b1);
    end

    // Asynchronous reset while a discard is in progress.
    findPendingWithValidId(found);
    if (found) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 32'h180, 32'd0);
      #1 rst_n = 1'b0;
      #1;
      clearModel();
      checkOutput("t6_pc", PC_if, RESET_PC);
      checkOutput("t6_instr", Instruction_id, NOP);
      checkOutput("t6_nextpc", NextPC_id, 32'd0);
      checkOutput("t6_valid", Valid_id, 32'd0);
      checkOutput("t6_req", imem_req, 32'd0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      #1;
      checkOutput("t6_first_req", imem_req, 32'd1);
      checkOutput("t6_first_addr", imem_addr, RESET_PC);
    end

    // Randomized traffic with random latency, stalls, redirects and wrap-around targets.
    randomLat = 1'b1;
    for (int i = 0; i < 800; i++) begin
      pcw = ($urandom_range(0, 3) != 0);
      z   = ($urandom_range(0, 4) == 0);
      j   = ($urandom_range(0, 6) == 0);
      jr  = ($urandom_range(0, 6) == 0);
      ba  = $urandom & 32'h0000_0FFF;
      ja  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : ($urandom & 32'h0000_3FFF);
      jra = $urandom;
      applyStimulus(pcw, z, j, jr, ba, ja, jra);
    end
    checkOutput("min_deliveries", 32'(delivered > 60), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
